mem_access: RTL and testbench

//  MEM pipeline stage directly downstream of the execute stage. Takes the 64-bit ALU result, store data,
//  mem_rw, is_load and func3, and runs one data-memory transaction per load/store over a req/ack handshake.

---
 rtl/mem_pkg.sv | 45 ++++
 rtl/mem_access_if.sv | 25 ++
 rtl/load_align.sv | 29 ++
 rtl/mem_access.sv | 140 ++++++++++++++
 tb/tb_mem_access.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared constants and helpers for the MEM stage: RV64I load/store func3
// codes, FSM state encoding and access-size helpers.
package mem_pkg;

  localparam int MEM_XLEN = 64;
  localparam int MEM_AW   = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // log2 of the access size in bytes; the signed/unsigned variants share it
  function automatic logic [1:0] access_size(input logic [2:0] f3);
    return f3[1:0];
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      2'd3:    return |off;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] base_strb(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the memory (slave).
interface mem_access_if
  import mem_pkg::*;
#(
  parameter int XLEN = MEM_XLEN,
  parameter int AW   = MEM_AW
);
  logic            dmem_req;
  logic            dmem_we;
  logic [AW-1:0]   dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic [7:0]      dmem_wstrb;
  logic [XLEN-1:0] dmem_rdata;
  logic            dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/load_align.sv
// Aligns a 64-bit read beat to the addressed byte and sign/zero-extends it
// according to the load func3.
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN = MEM_XLEN
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      off_i,
  input  logic [2:0]      func3_i,
  output logic [XLEN-1:0] data_o
);
  logic [XLEN-1:0] shifted;

  assign shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    data_o = shifted;
    case (func3_i)
      F3_B:    data_o = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
      F3_H:    data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      F3_W:    data_o = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      F3_BU:   data_o = {{(XLEN-8){1'b0}},  shifted[7:0]};
      F3_HU:   data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
      F3_WU:   data_o = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: data_o = shifted;
    endcase
  end
endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: one req/ack data-memory transaction per load/store,
// one-cycle pass-through for ALU ops, stall while a transaction is in flight.
module mem_access
  import mem_pkg::*;
#(
  parameter int XLEN = MEM_XLEN,
  parameter int AW   = MEM_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] result,
  input  logic [XLEN-1:0] data2,
  input  logic [2:0]      func3,
  input  logic            mem_rw,
  input  logic            is_load,
  input  logic [4:0]      rd,
  output logic            stall,
  mem_access_if.master    dmem,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            mem_fault
);
  state_e          state_q;
  logic            req_q, we_q, wb_valid_q, wb_we_q, fault_q;
  logic [AW-1:0]   addr_q;
  logic [2:0]      off_q, f3_q;
  logic [4:0]      rd_q, wb_rd_q;
  logic [7:0]      wstrb_q;
  logic [XLEN-1:0] wdata_q, wb_data_q, ld_data;

  logic [AW-1:0]   addr_d;
  logic [2:0]      off_d;
  logic [1:0]      size_d;
  logic            is_store_d, is_mem_d, illegal_d, misal_d;
  logic [7:0]      wstrb_d;
  logic [XLEN-1:0] wdata_d;

  assign addr_d     = result[AW-1:0];
  assign off_d      = addr_d[2:0];
  assign size_d     = access_size(func3);
  // mem_rw wins when both flags are set
  assign is_store_d = mem_rw;
  assign is_mem_d   = mem_rw | is_load;
  assign illegal_d  = is_store_d ? func3[2] : (func3 == 3'b111);
  assign misal_d    = is_misaligned(size_d, off_d);
  assign wstrb_d    = is_store_d ? (base_strb(size_d) << off_d) : 8'h00;

  // Replicate the store value so every lane the strobe selects sees it
  always_comb begin
    wdata_d = data2;
    case (size_d)
      2'd0:    wdata_d = {8{data2[7:0]}};
      2'd1:    wdata_d = {4{data2[15:0]}};
      2'd2:    wdata_d = {2{data2[31:0]}};
      default: wdata_d = data2;
    endcase
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata_i (dmem.dmem_rdata),
    .off_i   (off_q),
    .func3_i (f3_q),
    .data_o  (ld_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      off_q      <= '0;
      f3_q       <= '0;
      rd_q       <= '0;
      wstrb_q    <= '0;
      wdata_q    <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= '0;
      wb_data_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      fault_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            if (!is_mem_d) begin
              wb_valid_q <= 1'b1;
              wb_we_q    <= 1'b1;
              wb_rd_q    <= rd;
              wb_data_q  <= result;
            end else if (illegal_d || misal_d) begin
              fault_q <= 1'b1;
            end else begin
              req_q   <= 1'b1;
              we_q    <= is_store_d;
              addr_q  <= {addr_d[AW-1:3], 3'b000};
              off_q   <= off_d;
              f3_q    <= func3;
              rd_q    <= rd;
              wstrb_q <= wstrb_d;
              wdata_q <= wdata_d;
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // Read data is aligned straight off the bus in the ack cycle
          if (dmem.dmem_ack) begin
            req_q      <= 1'b0;
            state_q    <= ST_RESP;
            wb_valid_q <= 1'b1;
            wb_we_q    <= !we_q;
            wb_rd_q    <= rd_q;
            wb_data_q  <= we_q ? '0 : ld_data;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall           = (state_q != ST_IDLE);
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_wstrb = wstrb_q;
  assign wb_valid        = wb_valid_q;
  assign wb_we           = wb_we_q;
  assign wb_rd           = wb_rd_q;
  assign wb_data         = wb_data_q;
  assign mem_fault       = fault_q;
endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: pass-through, loads, stores, faults,
// reset during a transaction and first-cycle ack.
module tb_mem_access;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [63:0] result = '0;
  logic [63:0] data2 = '0;
  logic [2:0]  func3 = '0;
  logic        mem_rw = 1'b0;
  logic        is_load = 1'b0;
  logic [4:0]  rd = '0;
  logic        stall;
  logic        wb_valid, wb_we, mem_fault;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  int          checks = 0;
  int          failures = 0;

  mem_access_if dmem_bus ();

  mem_access dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .result    (result),
    .data2     (data2),
    .func3     (func3),
    .mem_rw    (mem_rw),
    .is_load   (is_load),
    .rd        (rd),
    .stall     (stall),
    .dmem      (dmem_bus.master),
    .wb_valid  (wb_valid),
    .wb_we     (wb_we),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data),
    .mem_fault (mem_fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [63:0] res, input logic [63:0] d2, input logic [2:0] f3,
                       input logic rw, input logic ld, input logic [4:0] r);
    in_valid = 1'b1; result = res; data2 = d2; func3 = f3; mem_rw = rw; is_load = ld; rd = r;
    step();
    in_valid = 1'b0; mem_rw = 1'b0; is_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    dmem_bus.dmem_ack = 1'b0;
    dmem_bus.dmem_rdata = '0;
    repeat (3) step();
    checks++;
    if ({stall, dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_wstrb, wb_valid, wb_we, mem_fault} !== 13'd0) begin
      failures++;
      $display("FAIL reset_ctrl: got stall=%b req=%b we=%b wstrb=%h wbv=%b wbwe=%b fault=%b required all 0",
               stall, dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_wstrb, wb_valid, wb_we, mem_fault);
    end
    checks++;
    if ({dmem_bus.dmem_addr, dmem_bus.dmem_wdata, wb_data, wb_rd} !== '0) begin
      failures++;
      $display("FAIL reset_data: got addr=%h wdata=%h wb_data=%h wb_rd=%0d required 0",
               dmem_bus.dmem_addr, dmem_bus.dmem_wdata, wb_data, wb_rd);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_alu_pass();
    issue(64'h1234, 64'h0, 3'b000, 1'b0, 1'b0, 5'd5);
    checks++;
    if ({wb_valid, wb_we, wb_rd, mem_fault, stall, dmem_bus.dmem_req} !== {1'b1, 1'b1, 5'd5, 3'b000}) begin
      failures++;
      $display("FAIL alu_ctrl: got wbv=%b wbwe=%b rd=%0d fault=%b stall=%b req=%b required 1 1 5 0 0 0",
               wb_valid, wb_we, wb_rd, mem_fault, stall, dmem_bus.dmem_req);
    end
    checks++;
    if (wb_data !== 64'h1234) begin
      failures++;
      $display("FAIL alu_data: got %h required %h", wb_data, 64'h1234);
    end
    step();
    checks++;
    if (wb_valid !== 1'b0) begin
      failures++;
      $display("FAIL alu_pulse: got wb_valid=%b required 0", wb_valid);
    end
  endtask

  task automatic test_lb_wait();
    int stall_cycles = 0;
    issue(64'h1003, 64'h0, 3'b000, 1'b0, 1'b1, 5'd9);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr, wb_valid} !== {1'b1, 1'b0, 32'h1000, 1'b0}) begin
        failures++;
        $display("FAIL lb_wait%0d: got req=%b we=%b addr=%h wbv=%b required 1 0 00001000 0",
                 i, dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_addr, wb_valid);
      end
      if (stall) stall_cycles++;
      step();
    end
    dmem_bus.dmem_ack = 1'b1;
    dmem_bus.dmem_rdata = 64'h0000_0000_8000_0000;
    if (stall) stall_cycles++;
    step();
    dmem_bus.dmem_ack = 1'b0;
    dmem_bus.dmem_rdata = '0;
    if (stall) stall_cycles++;
    checks++;
    if ({dmem_bus.dmem_req, wb_valid, wb_we, wb_rd} !== {1'b0, 1'b1, 1'b1, 5'd9}) begin
      failures++;
      $display("FAIL lb_resp: got req=%b wbv=%b wbwe=%b rd=%0d required 0 1 1 9",
               dmem_bus.dmem_req, wb_valid, wb_we, wb_rd);
    end
    checks++;
    if (wb_data !== 64'hFFFF_FFFF_FFFF_FF80) begin
      failures++;
      $display("FAIL lb_data: got %h required %h", wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    end
    step();
    if (stall) stall_cycles++;
    checks++;
    if (stall_cycles !== 5) begin
      failures++;
      $display("FAIL lb_stall_cycles: got %0d required 5", stall_cycles);
    end
  endtask

  task automatic test_store(input logic [63:0] addr, input logic [63:0] d2, input logic [2:0] f3,
                            input logic [7:0] exp_strb, input logic [63:0] exp_wdata);
    issue(addr, d2, f3, 1'b1, 1'b0, 5'd3);
    checks++;
    if ({dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_wstrb, dmem_bus.dmem_addr} !==
        {1'b1, 1'b1, exp_strb, addr[31:3], 3'b000}) begin
      failures++;
      $display("FAIL st_req f3=%0d: got req=%b we=%b wstrb=%h addr=%h required 1 1 %h %h",
               f3, dmem_bus.dmem_req, dmem_bus.dmem_we, dmem_bus.dmem_wstrb, dmem_bus.dmem_addr,
               exp_strb, {addr[31:3], 3'b000});
    end
    checks++;
    if (dmem_bus.dmem_wdata !== exp_wdata) begin
      failures++;
      $display("FAIL st_wdata f3=%0d: got %h required %h", f3, dmem_bus.dmem_wdata, exp_wdata);
    end
    dmem_bus.dmem_ack = 1'b1;
    step();
    dmem_bus.dmem_ack = 1'b0;
    checks++;
    if ({wb_valid, wb_we, stall, dmem_bus.dmem_req} !== 4'b1010) begin
      failures++;
      $display("FAIL st_resp f3=%0d: got wbv=%b wbwe=%b stall=%b req=%b required 1 0 1 0",
               f3, wb_valid, wb_we, stall, dmem_bus.dmem_req);
    end
    step();
  endtask

  task automatic test_fault(input logic [63:0] addr, input logic [2:0] f3, input logic rw, input logic ld);
    issue(addr, 64'h0, f3, rw, ld, 5'd4);
    checks++;
    if ({mem_fault, wb_valid, dmem_bus.dmem_req, stall} !== 4'b1000) begin
      failures++;
      $display("FAIL fault f3=%0d addr=%h: got fault=%b wbv=%b req=%b stall=%b required 1 0 0 0",
               f3, addr, mem_fault, wb_valid, dmem_bus.dmem_req, stall);
    end
    step();
    checks++;
    if ({mem_fault, dmem_bus.dmem_req} !== 2'b00) begin
      failures++;
      $display("FAIL fault_pulse f3=%0d: got fault=%b req=%b required 0 0", f3, mem_fault, dmem_bus.dmem_req);
    end
  endtask

  task automatic test_reset_in_wait();
    issue(64'h4000, 64'h0, 3'b011, 1'b0, 1'b1, 5'd2);
    checks++;
    if (dmem_bus.dmem_req !== 1'b1) begin
      failures++;
      $display("FAIL rst_wait_pre: got req=%b required 1", dmem_bus.dmem_req);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({dmem_bus.dmem_req, stall} !== 2'b00) begin
      failures++;
      $display("FAIL rst_wait_drop: got req=%b stall=%b required 0 0", dmem_bus.dmem_req, stall);
    end
    step();
    rst = 1'b1;
    step();
    issue(64'h55, 64'h0, 3'b000, 1'b0, 1'b0, 5'd7);
    checks++;
    if ({wb_valid, wb_we, wb_rd, wb_data} !== {1'b1, 1'b1, 5'd7, 64'h55}) begin
      failures++;
      $display("FAIL rst_wait_after: got wbv=%b wbwe=%b rd=%0d data=%h required 1 1 7 55",
               wb_valid, wb_we, wb_rd, wb_data);
    end
    step();
  endtask

  task automatic test_load_first_ack(input logic [63:0] addr, input logic [2:0] f3,
                                     input logic [63:0] rdata, input logic [63:0] exp);
    issue(addr, 64'h0, f3, 1'b0, 1'b1, 5'd11);
    dmem_bus.dmem_ack = 1'b1;
    dmem_bus.dmem_rdata = rdata;
    step();
    dmem_bus.dmem_ack = 1'b0;
    dmem_bus.dmem_rdata = '0;
    checks++;
    if ({wb_valid, wb_we, wb_data} !== {1'b1, 1'b1, exp}) begin
      failures++;
      $display("FAIL ld_first_ack f3=%0d: got wbv=%b wbwe=%b data=%h required 1 1 %h",
               f3, wb_valid, wb_we, wb_data, exp);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_alu_pass();
    test_lb_wait();
    test_store(64'h2006, 64'hABCD, 3'b001, 8'hC0, 64'hABCD_ABCD_ABCD_ABCD);
    test_store(64'h2005, 64'h77, 3'b000, 8'h20, 64'h7777_7777_7777_7777);
    test_store(64'h2004, 64'h1122_3344, 3'b010, 8'hF0, 64'h1122_3344_1122_3344);
    test_store(64'h2008, 64'h0102_0304_0506_0708, 3'b011, 8'hFF, 64'h0102_0304_0506_0708);
    test_fault(64'h3002, 3'b010, 1'b0, 1'b1);
    test_fault(64'h3000, 3'b111, 1'b0, 1'b1);
    test_fault(64'h3000, 3'b100, 1'b1, 1'b0);
    test_fault(64'h3004, 3'b011, 1'b1, 1'b1);
    test_reset_in_wait();
    test_load_first_ack(64'h8, 3'b110, 64'h0000_0000_F000_0000, 64'h0000_0000_F000_0000);
    test_load_first_ack(64'h8, 3'b010, 64'h0000_0000_F000_0000, 64'hFFFF_FFFF_F000_0000);
    test_load_first_ack(64'h12, 3'b001, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001);
    test_load_first_ack(64'h18, 3'b011, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
